avalon_ram_responder: RTL and testbench
=======================================

// Module: avalon_ram_responder
// PURPOSE
//  Avalon-MM slave memory that answers the bus requests issued by mips_cpu_bus.
//  It maps a data region at byte address 0 and an instruction region at the MIPS reset vector.
//  It inserts programmable wait states on waitrequest and honours byteenable on writes.
//  It provides a side debug read port so benches can check results without bus traffic.
// PARAMETERS
//  DATA_WORDS    1024          depth of data region, words; region spans 0 .. 4*DATA_WORDS-1
//  INSTR_WORDS   1024          depth of instruction region, words
//  RESET_VECTOR  32'hBFC00000  byte base of instruction region
//  WAIT_CYCLES   1             stall cycles per transfer; legal range 1..15
//  RANDOM_WAIT   0             1: add 0..3 extra stall cycles taken from LFSR[1:0]
//  INIT_FILE     ""            if non-empty, $readmemh into instruction region at elaboration
// PORTS
//  clk          in   1   clock; everything is on the rising edge
//  reset        in   1   synchronous, active-high
//  address      in   32  byte address from master
//  read         in   1   read request
//  write        in   1   write request
//  byteenable   in   4   write lane enables; bit n selects writedata[8n+7:8n]
//  writedata    in   32  write data
//  waitrequest  out  1   high = transfer not yet accepted; master holds request
//  readdata     out  32  read data; valid only in the ACK cycle of a read
//  prot_err     out  1   sticky flag: read&write together, unaligned, or unmapped access
//  dbg_addr     in   32  byte address for the debug read port
//  dbg_rdata    out  32  combinational word at dbg_addr; 0 if dbg_addr is unmapped
// BEHAVIOUR
//  FSM states: IDLE, STALL, ACK. Reset values: state=IDLE, waitrequest=0, readdata=0,
//   prot_err=0, LFSR=8'hA5, counter=0. Reset does NOT clear memory contents.
//  waitrequest = (IDLE & (read|write)) | STALL. It is low in ACK and in idle IDLE.
//  IDLE with read|write: capture address, byteenable, writedata and op.
//   Load cnt = WAIT_CYCLES-1 (+LFSR[1:0] if RANDOM_WAIT). Go to ACK if cnt==0, else STALL.
//  STALL: decrement cnt each cycle; on cnt==1 go to ACK.
//   If read and write both drop low, abort to IDLE with no memory effect.
//  Readdata latches the captured word on the edge that enters ACK.
//  ACK: waitrequest=0 for exactly one cycle; writes commit on the edge leaving ACK; next state IDLE.
//  Latency: request to completion is WAIT_CYCLES+1 cycles (+random extra). Every access re-stalls.
//  Decode uses the word index address[31:2].
//   - Instruction hit when RESET_VECTOR <= address < RESET_VECTOR + 4*INSTR_WORDS.
//   - Data hit when address < 4*DATA_WORDS. Both regions are writable.
//  Unmapped access: read returns 0, write is dropped, prot_err set. The handshake still completes.
//  address[1:0]!=0: access the word at address & ~3, set prot_err.
//  read&write together: perform read only, set prot_err.
//  byteenable is ignored on reads, which always return the full word.
//   A write with byteenable==0 completes but changes nothing.
//  LFSR: 8-bit, taps 8,6,5,4. Advances once per accepted transfer.
//  Reset mid-transfer: return to IDLE next edge, pending write discarded, waitrequest=0.
// TESTING
//  1. WAIT_CYCLES=1: read of 0xBFC00000 holding 32'h8C010064.
//     -> waitrequest high 1 cycle, then readdata=8C010064 in the ACK cycle.
//  2. Write 0x000000C8 with data 123 and be=1111, then read it back.
//     -> 123; dbg_addr=0xC8 also gives dbg_rdata=123.
//  3. Word holds 32'hFFFFFFFF; write data 32'h00AB0000 with be=0100.
//     -> word reads 32'hFFABFFFF.
//  4. WAIT_CYCLES=3: check stall length; drop read in the 2nd stall cycle.
//     -> IDLE, no ACK, memory unchanged.
//  5. Read address 0x40000000; separately assert read+write together.
//     -> readdata=0, prot_err=1, stays 1 until reset.
//  6. Reset asserted in the STALL of a write to 0x10.
//     -> word 0x10 unchanged, waitrequest=0 next cycle.

Source files
------------

// File: rtl/avalon_ram_responder.sv
// Avalon-MM slave RAM: a data region at byte 0 and an instruction region at the
// MIPS reset vector, programmable wait states, byte-lane writes and a
// combinational debug read port.
module avalon_ram_responder #(
  parameter int unsigned DATA_WORDS   = 1024,
  parameter int unsigned INSTR_WORDS  = 1024,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter bit          RANDOM_WAIT  = 1'b0,
  parameter              INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        prot_err,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_rdata
);

  localparam int unsigned DAW = (DATA_WORDS  > 1) ? $clog2(DATA_WORDS)  : 1;
  localparam int unsigned IAW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ACK   = 2'd2
  } state_t;

  typedef struct packed {
    logic           d_hit;
    logic           i_hit;
    logic [DAW-1:0] d_idx;
    logic [IAW-1:0] i_idx;
  } dec_t;

  // Word-index decode of a byte address into region hit flags and array indices.
  function automatic dec_t decode(input logic [31:0] a);
    dec_t        r;
    logic [29:0] w;
    logic [29:0] off;
    r       = '0;
    w       = a[31:2];
    off     = w - RESET_VECTOR[31:2];
    r.d_hit = ({2'b00, w} < 32'(DATA_WORDS));
    r.i_hit = (w >= RESET_VECTOR[31:2]) && ({2'b00, off} < 32'(INSTR_WORDS));
    r.d_idx = w[DAW-1:0];
    r.i_idx = off[IAW-1:0];
    return r;
  endfunction

  logic [31:0] dmem [DATA_WORDS];
  logic [31:0] imem [INSTR_WORDS];

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [4:0]  load_cnt;
  logic [29:0] cap_widx;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic        cap_wr;
  logic [7:0]  lfsr_q;
  logic [7:0]  lfsr_next;
  logic        accept;
  logic        enter_ack;
  logic        ack_is_write;
  logic        wait_raw;
  dec_t        bus_dec, cap_dec, rd_dec, dbg_dec;
  logic [31:0] rd_word;

  assign bus_dec   = decode(address);
  assign cap_dec   = decode({cap_widx, 2'b00});
  assign dbg_dec   = decode(dbg_addr);
  // Entering ACK straight from IDLE reads the live address, otherwise the captured one.
  assign rd_dec    = (state_q == IDLE) ? bus_dec : cap_dec;

  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign load_cnt  = 5'(WAIT_CYCLES - 1) + (RANDOM_WAIT ? {3'b000, lfsr_q[1:0]} : 5'd0);
  assign accept    = (state_q == IDLE) && (read || write);
  assign enter_ack = (state_d == ACK) && (state_q != ACK);
  assign ack_is_write = (state_q == IDLE) ? (write & ~read) : cap_wr;

  // Word selected for the bus read path; unmapped reads return zero.
  always_comb begin
    rd_word = '0;
    if (rd_dec.d_hit)      rd_word = dmem[rd_dec.d_idx];
    else if (rd_dec.i_hit) rd_word = imem[rd_dec.i_idx];
  end

  // Debug port: combinational lookup, zero when unmapped.
  always_comb begin
    dbg_rdata = '0;
    if (dbg_dec.d_hit)      dbg_rdata = dmem[dbg_dec.d_idx];
    else if (dbg_dec.i_hit) dbg_rdata = imem[dbg_dec.i_idx];
  end

  // Next-state and waitrequest decode.
  always_comb begin
    state_d  = state_q;
    wait_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read || write) begin
          wait_raw = 1'b1;
          state_d  = (load_cnt == 5'd0) ? ACK : STALL;
        end
      end
      STALL: begin
        wait_raw = 1'b1;
        if (!read && !write)    state_d = IDLE;
        else if (cnt_q == 5'd1) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    waitrequest = wait_raw & ~reset;
  end

  // State, capture registers, wait counter, read latch, sticky error and LFSR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cap_widx  <= '0;
      cap_be    <= '0;
      cap_wdata <= '0;
      cap_wr    <= 1'b0;
      readdata  <= '0;
      prot_err  <= 1'b0;
      lfsr_q    <= 8'hA5;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cap_widx  <= address[31:2];
        cap_be    <= byteenable;
        cap_wdata <= writedata;
        cap_wr    <= write & ~read;
        cnt_q     <= load_cnt;
        lfsr_q    <= lfsr_next;
        if ((read && write) || (address[1:0] != 2'b00) ||
            !(bus_dec.d_hit || bus_dec.i_hit))
          prot_err <= 1'b1;
      end else if (state_q == STALL) begin
        cnt_q <= cnt_q - 5'd1;
      end
      if (enter_ack && !ack_is_write) readdata <= rd_word;
    end
  end

  // Memory write: commits on the edge leaving ACK; reset in ACK discards it.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == ACK) && cap_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (cap_be[i]) begin
          if (cap_dec.d_hit)      dmem[cap_dec.d_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
          else if (cap_dec.i_hit) imem[cap_dec.i_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_ram_responder.sv
// Directed and randomized checks of avalon_ram_responder: two instances, one
// with a single wait state and one with three, against a word-map model.
module tb_avalon_ram_responder;

  localparam int unsigned W0 = 1;
  localparam int unsigned W1 = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0][31:0] address, writedata, readdata, dbg_addr, dbg_rdata;
  logic [1:0]       read, write, waitrequest, prot_err;
  logic [1:0][3:0]  byteenable;

  int unsigned ncomp = 0;
  int unsigned nfail = 0;

  logic [31:0] mdl0 [int unsigned];
  logic [31:0] mdl1 [int unsigned];

  always #5 clk = ~clk;

  avalon_ram_responder #(.WAIT_CYCLES(W0)) u_w1 (
    .clk(clk), .reset(reset), .address(address[0]), .read(read[0]), .write(write[0]),
    .byteenable(byteenable[0]), .writedata(writedata[0]), .waitrequest(waitrequest[0]),
    .readdata(readdata[0]), .prot_err(prot_err[0]), .dbg_addr(dbg_addr[0]),
    .dbg_rdata(dbg_rdata[0]));

  avalon_ram_responder #(.WAIT_CYCLES(W1)) u_w3 (
    .clk(clk), .reset(reset), .address(address[1]), .read(read[1]), .write(write[1]),
    .byteenable(byteenable[1]), .writedata(writedata[1]), .waitrequest(waitrequest[1]),
    .readdata(readdata[1]), .prot_err(prot_err[1]), .dbg_addr(dbg_addr[1]),
    .dbg_rdata(dbg_rdata[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit mapped(input logic [31:0] a);
    return (a < 32'h0000_1000) || (a >= 32'hBFC0_0000 && a < 32'hBFC0_1000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] expect_word(input int s, input logic [31:0] a);
    int unsigned k;
    k = a >> 2;
    if (!mapped(a)) return 32'h0;
    if (s == 0) return mdl0.exists(k) ? mdl0[k] : 32'h0;
    return mdl1.exists(k) ? mdl1[k] : 32'h0;
  endfunction

  function automatic void model_write(input int s, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] be);
    int unsigned k;
    k = a >> 2;
    if (!mapped(a)) return;
    if (s == 0) mdl0[k] = merge(mdl0.exists(k) ? mdl0[k] : 32'h0, d, be);
    else        mdl1[k] = merge(mdl1.exists(k) ? mdl1[k] : 32'h0, d, be);
  endfunction

  // One complete bus transfer; returns data seen in the ACK cycle and stall count.
  task automatic bus(input int s, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] d,
                     output logic [31:0] rdata, output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    rdata = 'x;
    @(posedge clk); #1;
    read[s] = rd; write[s] = wr; address[s] = a; byteenable[s] = be; writedata[s] = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (waitrequest[s]) waits++;
      else begin
        got   = 1'b1;
        rdata = readdata[s];
      end
    end
    if (!got) check("ack_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    read[s] = 1'b0; write[s] = 1'b0;
    if (wr && !rd) model_write(s, a, d, be);
  endtask

  task automatic do_read(input int s, input logic [31:0] a, input string tag);
    logic [31:0] rdat;
    int          w;
    bus(s, 1'b1, 1'b0, a, 4'hF, 32'h0, rdat, w);
    check({tag, "_data"}, rdat, expect_word(s, a));
    check({tag, "_lat"}, 32'(w), (s == 0) ? W0 : W1);
  endtask

  task automatic do_write(input int s, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input string tag);
    logic [31:0] rdat;
    int          w;
    bus(s, 1'b0, 1'b1, a, be, d, rdat, w);
    check({tag, "_wlat"}, 32'(w), (s == 0) ? W0 : W1);
  endtask

  task automatic dbg_check(input int s, input logic [31:0] a, input string tag);
    dbg_addr[s] = a;
    #1;
    check(tag, dbg_rdata[s], expect_word(s, a));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rdat, pool [6];
    int          w;
    reset = 1'b1;
    read = '0; write = '0; address = '0; writedata = '0; byteenable = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_wait", 32'(waitrequest[s]), 32'd0);
      check("rst_rdata", readdata[s], 32'h0);
      check("rst_perr", 32'(prot_err[s]), 32'd0);
    end

    // Instruction fetch at the reset vector, single wait state.
    do_write(0, 32'hBFC0_0000, 32'h8C01_0064, 4'hF, "t1");
    do_read(0, 32'hBFC0_0000, "t1_rd");
    // Full-word write and read back, plus debug port.
    do_write(0, 32'h0000_00C8, 32'd123, 4'hF, "t2");
    do_read(0, 32'h0000_00C8, "t2_rd");
    dbg_check(0, 32'h0000_00C8, "t2_dbg");
    // Single-lane write into an all-ones word, then an empty-mask write.
    do_write(0, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, "t3a");
    do_write(0, 32'h0000_0100, 32'h00AB_0000, 4'b0100, "t3b");
    bus(0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, rdat, w);
    check("t3_lane", rdat, 32'hFFAB_FFFF);
    do_write(0, 32'h0000_0100, 32'h0, 4'b0000, "t3c");
    do_read(0, 32'h0000_0100, "t3_be0");
    // Last words of each region are still mapped.
    do_write(0, 32'h0000_0FFC, 32'hCAFE_0FFC, 4'hF, "bnd_d");
    do_read(0, 32'h0000_0FFC, "bnd_d_rd");
    do_write(0, 32'hBFC0_0FFC, 32'hCAFE_1FFC, 4'hF, "bnd_i");
    do_read(0, 32'hBFC0_0FFC, "bnd_i_rd");
    check("clean_perr", 32'(prot_err[0]), 32'd0);

    // Three wait states: latency and aborts in the second stall cycle.
    do_write(1, 32'h0000_0020, 32'h5555_AAAA, 4'hF, "t4w");
    do_read(1, 32'h0000_0020, "t4_rd");
    @(posedge clk); #1;
    read[1] = 1'b1; address[1] = 32'h0000_0020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    read[1] = 1'b0;
    @(negedge clk);
    check("t4_stall2_wait", 32'(waitrequest[1]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_abort_wait", 32'(waitrequest[1]), 32'd0);
    @(posedge clk); #1;
    write[1] = 1'b1; address[1] = 32'h0000_0020; writedata[1] = 32'h1234_5678;
    byteenable[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    write[1] = 1'b0;
    repeat (3) @(posedge clk);
    dbg_check(1, 32'h0000_0020, "t4_abort_mem");
    do_read(1, 32'h0000_0020, "t4_after");

    // Unmapped read and simultaneous read+write both raise the sticky error.
    do_read(0, 32'h4000_0000, "t5_unmap");
    check("t5_perr", 32'(prot_err[0]), 32'd1);
    dbg_check(0, 32'h4000_0000, "t5_dbg_unmap");
    do_read(0, 32'h0000_00C8, "t5_clean");
    check("t5_sticky", 32'(prot_err[0]), 32'd1);
    check("t5_rw_pre", 32'(prot_err[1]), 32'd0);
    bus(1, 1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'hDEAD_BEEF, rdat, w);
    check("t5_rw_data", rdat, expect_word(1, 32'h0000_0020));
    dbg_check(1, 32'h0000_0020, "t5_rw_mem");
    check("t5_rw_perr", 32'(prot_err[1]), 32'd1);
    do_reset();
    @(negedge clk);
    check("t5_rst_perr0", 32'(prot_err[0]), 32'd0);
    check("t5_rst_perr1", 32'(prot_err[1]), 32'd0);

    // Misaligned accesses hit the containing word.
    do_read(0, 32'h0000_00CA, "ua_rd");
    check("ua_perr", 32'(prot_err[0]), 32'd1);
    do_write(0, 32'h0000_0102, 32'h0102_0304, 4'hF, "ua_wr");
    do_read(0, 32'h0000_0100, "ua_wr_rd");
    // First words past each region are unmapped.
    do_reset();
    do_read(0, 32'h0000_1000, "miss_d");
    check("miss_d_perr", 32'(prot_err[0]), 32'd1);
    do_reset();
    do_read(0, 32'hBFC0_1000, "miss_i_hi");
    check("miss_i_hi_perr", 32'(prot_err[0]), 32'd1);
    do_reset();
    do_read(0, 32'hBFBF_FFFC, "miss_i_lo");
    check("miss_i_lo_perr", 32'(prot_err[0]), 32'd1);

    // Reset during the stall of a write leaves memory untouched.
    do_write(1, 32'h0000_0010, 32'h0BAD_F00D, 4'hF, "t6w");
    @(posedge clk); #1;
    write[1] = 1'b1; address[1] = 32'h0000_0010; writedata[1] = 32'hFFFF_FFFF;
    byteenable[1] = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; write[1] = 1'b0;
    @(negedge clk);
    check("t6_wait", 32'(waitrequest[1]), 32'd0);
    repeat (4) @(posedge clk);
    dbg_check(1, 32'h0000_0010, "t6_mem");

    // Randomized partial writes against the model, both wait settings.
    do_reset();
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < 6; p++) begin
        pool[p] = ($urandom_range(0, 1) != 0 ? 32'hBFC0_0000 : 32'h0) +
                  ($urandom_range(0, 1023) << 2);
        do_write(s, pool[p], $urandom, 4'hF, "rnd_init");
      end
      for (int n = 0; n < 12; n++) begin
        do_write(s, pool[$urandom_range(0, 5)], $urandom, 4'($urandom_range(0, 15)), "rnd_w");
      end
      for (int p = 0; p < 6; p++) begin
        do_read(s, pool[p], "rnd_rd");
        dbg_check(s, pool[p], "rnd_dbg");
      end
      check("rnd_perr", 32'(prot_err[s]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
